// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: 2-bit counter encodings and the
// counter values used at reset and on allocation.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_SNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state function (purely combinational).
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF lookup, EX-stage
// training, mispredict/redirect generation and saturating statistics.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        flush_btb,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [31:0]        stat_lookups_q, stat_lookups_d;
  logic [31:0]        stat_mispredicts_q, stat_mispredicts_d;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit;
  logic               ex_br, ex_nb;
  logic [1:0]         ctr_upd;
  logic               unused_pc_bits;

  assign if_idx = if_pc[INDEX_W+1:2];
  assign if_tag = if_pc[31:INDEX_W+2];
  assign ex_idx = ex_pc[INDEX_W+1:2];
  assign ex_tag = ex_pc[31:INDEX_W+2];
  assign unused_pc_bits = ^if_pc[1:0];

  assign if_hit = if_valid && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_br  = ex_valid && ex_is_branch;
  assign ex_nb  = ex_valid && !ex_is_branch;

  always_comb begin
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : 32'd0;
  end

  // A non-branch predicted taken means its PC aliased onto a branch entry.
  always_comb begin
    mispredict = 1'b0;
    if (ex_br)
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target));
    else if (ex_nb)
      mispredict = ex_pred_taken;
    redirect_pc = 32'd0;
    if (mispredict)
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
  end

  sat_counter2 u_ctr (
    .ctr      (ctr_q[ex_idx]),
    .inc      (ex_taken),
    .ctr_next (ctr_upd)
  );

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (ex_br) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ctr_upd;
        if (ex_taken) target_d[ex_idx] = ex_target;
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = CTR_ALLOC;
      end
    end else if (ex_nb && ex_pred_taken && ex_hit) begin
      valid_d[ex_idx] = 1'b0;
    end
    // Flush is applied last so it overrides any same-cycle allocation.
    if (flush_btb) valid_d = '0;
  end

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (if_valid && (stat_lookups_q != 32'hFFFF_FFFF))
      stat_lookups_d = stat_lookups_q + 32'd1;
    if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q            <= '0;
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else begin
      valid_q            <= valid_d;
      ctr_q              <= ctr_d;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector table with a scoreboard
// queue, plus hand sequences for counter saturation and asynchronous reset.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken, flush_btb;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, stat_lookups, stat_mispredicts;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush_btb(flush_btb),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ifv;
    logic [31:0] ifpc;
    logic        exv, br;
    logic [31:0] expc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        fl;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] lk;
    logic [31:0] mc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_lookups = 0;
  logic [31:0] m_mispredicts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic v(input string name, input logic ifv, input logic [31:0] ifpc,
                   input logic exv, input logic br, input logic [31:0] expc,
                   input logic tk, input logic [31:0] tgt, input logic ptk,
                   input logic [31:0] ptgt, input logic fl,
                   input logic e_pt, input logic [31:0] e_tgt,
                   input logic e_mp, input logic [31:0] e_rd);
    vec_t t;
    t.name = name; t.ifv = ifv; t.ifpc = ifpc; t.exv = exv; t.br = br;
    t.expc = expc; t.tk = tk; t.tgt = tgt; t.ptk = ptk; t.ptgt = ptgt;
    t.fl = fl; t.e_pt = e_pt; t.e_tgt = e_tgt; t.e_mp = e_mp; t.e_rd = e_rd;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_pc = 0; ex_valid = 0; ex_is_branch = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    flush_btb = 0;
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    check({e.name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.pt});
    check({e.name, ".pred_target"}, pred_target, e.tgt);
    check({e.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mp});
    check({e.name, ".redirect_pc"}, redirect_pc, e.rd);
    check({e.name, ".stat_lookups"}, stat_lookups, e.lk);
    check({e.name, ".stat_mispredicts"}, stat_mispredicts, e.mc);
    $display("vec %-12s pt=%0d tgt=%h mp=%0d rd=%h lk=%0d mc=%0d",
             e.name, pred_taken, pred_target, mispredict, redirect_pc,
             stat_lookups, stat_mispredicts);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] preload;

    // Index is pc[5:2], tag pc[31:6]: 0x100, 0x140 and 0x200 share index 0.
    v("lookup_cold", 1, 32'h100, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("alloc_mp",    1, 32'h100, 1,1,32'h100,1,32'h80,0,0,0,    0,0,1,32'h80);
    v("hit_taken",   1, 32'h100, 0,0,0,0,0,0,0,0,               1,32'h80,0,0);
    v("nt1_mp",      1, 32'h100, 1,1,32'h100,0,0,1,32'h80,0,    1,32'h80,1,32'h104);
    v("nt2_ok",      1, 32'h100, 1,1,32'h100,0,0,0,0,0,         0,0,0,0);
    v("after_nt2",   1, 32'h100, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("retrain1",    0, 0,       1,1,32'h100,1,32'h80,0,0,0,    0,0,1,32'h80);
    v("retrain2",    1, 32'h100, 1,1,32'h100,1,32'h80,0,0,0,    0,0,1,32'h80);
    v("retrained",   1, 32'h100, 0,0,0,0,0,0,0,0,               1,32'h80,0,0);
    v("alias_miss",  1, 32'h140, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("alias_alloc", 0, 0,       1,1,32'h140,1,32'h300,0,0,0,   0,0,1,32'h300);
    v("evicted",     1, 32'h100, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("alias_hit",   1, 32'h140, 0,0,0,0,0,0,0,0,               1,32'h300,0,0);
    v("tgt_mp",      0, 0,       1,1,32'h140,1,32'h340,1,32'h300,0, 0,0,1,32'h340);
    v("tgt_ok",      1, 32'h140, 1,1,32'h140,1,32'h340,1,32'h340,0, 1,32'h340,0,0);
    v("flush_upd",   0, 0,       1,1,32'h200,1,32'h400,0,0,1,   0,0,1,32'h400);
    v("flush_miss",  1, 32'h200, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("flush_all",   1, 32'h140, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("realloc",     0, 0,       1,1,32'h100,1,32'h80,0,0,0,    0,0,1,32'h80);
    v("nb_alias",    1, 32'h100, 1,0,32'h100,0,0,1,0,0,         1,32'h80,1,32'h104);
    v("nb_inval",    1, 32'h100, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("exv_off",     1, 32'h100, 0,1,32'h100,1,32'h80,0,0,0,    0,0,0,0);
    v("exv_off_chk", 1, 32'h100, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("nb_ok",       0, 0,       1,0,32'h180,0,0,0,0,0,         0,0,0,0);
    v("nt_miss",     0, 0,       1,1,32'h180,0,0,0,0,0,         0,0,0,0);
    v("nt_miss_chk", 1, 32'h180, 0,0,0,0,0,0,0,0,               0,0,0,0);
    v("pc_wrap",     0, 0,       1,0,32'hFFFF_FFFC,0,0,1,0,0,   0,0,1,32'h0);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset.pred_taken", {31'd0, pred_taken}, 32'd0);
    check("reset.stat_lookups", stat_lookups, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if_valid = vecs[i].ifv; if_pc = vecs[i].ifpc;
      ex_valid = vecs[i].exv; ex_is_branch = vecs[i].br; ex_pc = vecs[i].expc;
      ex_taken = vecs[i].tk; ex_target = vecs[i].tgt;
      ex_pred_taken = vecs[i].ptk; ex_pred_target = vecs[i].ptgt;
      flush_btb = vecs[i].fl;
      e.name = vecs[i].name; e.pt = vecs[i].e_pt; e.tgt = vecs[i].e_tgt;
      e.mp = vecs[i].e_mp; e.rd = vecs[i].e_rd;
      e.lk = m_lookups; e.mc = m_mispredicts;
      sb.push_back(e);
      #1;
      compare_head();
      if (vecs[i].ifv) m_lookups++;
      if (vecs[i].e_mp) m_mispredicts++;
    end

    @(negedge clk);
    idle_inputs();
    #1;
    check("final.stat_lookups", stat_lookups, m_lookups);
    check("final.stat_mispredicts", stat_mispredicts, m_mispredicts);

    // Preload the lookup counter just below saturation, then count past it.
    force dut.stat_lookups_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_lookups_q;
    #1;
    preload = stat_lookups;
    if (preload == 32'hFFFF_FFFE) begin
      @(negedge clk);
      if_valid = 1; if_pc = 32'h500;
      @(negedge clk);
      #1;
      check("sat.reach_max", stat_lookups, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      #1;
      check("sat.hold_max", stat_lookups, 32'hFFFF_FFFF);
      $display("sat stat_lookups=%h", stat_lookups);
    end else begin
      $display("sat preload not applied (read %h), saturation sequence skipped", preload);
    end

    // Allocate 0x240, confirm the hit, then assert reset mid-cycle.
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h240; ex_taken = 1; ex_target = 32'h500;
    @(negedge clk);
    idle_inputs();
    if_valid = 1; if_pc = 32'h240;
    #1;
    check("pre_rst.pred_taken", {31'd0, pred_taken}, 32'd1);
    check("pre_rst.pred_target", pred_target, 32'h500);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.pred_taken", {31'd0, pred_taken}, 32'd0);
    check("async_rst.pred_target", pred_target, 32'd0);
    check("async_rst.mispredict", {31'd0, mispredict}, 32'd0);
    check("async_rst.redirect_pc", redirect_pc, 32'd0);
    check("async_rst.stat_lookups", stat_lookups, 32'd0);
    check("async_rst.stat_mispredicts", stat_mispredicts, 32'd0);
    $display("async reset pt=%0d lk=%0d", pred_taken, stat_lookups);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst.pred_taken", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    #1;
    check("post_rst.stat_lookups", stat_lookups, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-side consumer of resolved branch targets in the pipelined RV32I core. At IF it predicts taken/not-taken and the target for the current PC from a direct-mapped table. At EX it is trained with the resolved outcome and target produced by the branch destination logic. It flags mispredictions and supplies the corrective fetch PC. It also keeps saturating lookup and mispredict statistics.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, 4..256.
- INDEX_W, $clog2(ENTRIES), index width; derived, never overridden.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_valid  input  1  IF stage holds a real fetch this cycle.
- if_pc  input  32  PC being fetched.
- pred_taken  output  1  prediction for if_pc (combinational).
- pred_target  output  32  predicted target; 0 when pred_taken=0.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  32  PC of EX instruction.
- ex_taken  input  1  resolved direction.
- ex_target  input  32  resolved target (cur_pc + (imm_B << 1)).
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- ex_pred_target  input  32  predicted target carried down the pipe.
- flush_btb  input  1  invalidate all entries.
- mispredict  output  1  EX prediction was wrong; pipeline must squash IF/ID (combinational).
- redirect_pc  output  32  correct next PC when mispredict=1, else 0.
- stat_lookups  output  32  count of if_valid cycles.
- stat_mispredicts  output  32  count of mispredict cycles.

## Operation
- Address split:
  - index = pc[INDEX_W+1:2].
  - tag = pc[31:INDEX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[31:0], ctr[1:0] (2-bit saturating; 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup:
  - hit = if_valid && valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : 0.
- Mispredict, for branches (ex_valid && ex_is_branch): ex_taken != ex_pred_taken, or (ex_taken && ex_target != ex_pred_target).
- Mispredict, for non-branches (ex_valid && !ex_is_branch): ex_pred_taken=1 (tag alias).
- redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 4 (32-bit wrap).
- Update when ex_valid && ex_is_branch:
  - Entry hit: ctr saturating increment if taken, decrement if not. Target overwritten with ex_target when taken.
  - Entry miss, taken: allocate, replacing the existing entry. Set valid=1, tag, target=ex_target, ctr=10.
  - Entry miss, not taken: no change.
- Update on a non-branch mispredict: clear valid[idx(ex_pc)] when the tag matches.
- flush_btb clears every valid bit. Targets, tags and counters are retained but unused.
- Statistics counters increment by 1 per qualifying cycle and saturate at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous, rst_n=0):
  - All valid bits 0, all ctr 00, stat counters 0.
  - Consequently pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0 whenever ex_valid=0.
- Lookup and mispredict/redirect are zero-latency combinational paths. Table writes take effect at the next rising edge.
- Same-index lookup and update in one cycle: lookup returns pre-update contents.
- flush_btb and update in the same cycle: flush wins; the entry ends invalid.
- Reset mid-operation clears state immediately, without waiting for clk; pending updates are lost.
- ex_valid=0 suppresses mispredict, update and stat_mispredicts regardless of other EX inputs.

## Structure
- Shared package `bp_pkg`:
  - counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST);
  - reset counter value;
  - allocate counter value (CTR_WT).
- Sub-module `sat_counter2`: 2-bit saturating up/down next-state function. Instantiated once on the update path.
- The table is a register array, not SRAM, because lookup is asynchronous read.

## Test plan
- Reset, then if_pc=0x100 with if_valid=1 -> pred_taken=0, pred_target=0, stat_lookups=1 after one edge.
- EX taken branch at 0x100, target 0x80, predicted NT -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice after allocation: ctr 10->01->00; first NT gives mispredict=1, redirect_pc=0x104. Then lookup -> pred_taken=0.
- Alias, ENTRIES=16: allocate 0x100 taken, then lookup 0x140 (same index, different tag) -> pred_taken=0. Allocating 0x140 replaces the entry; lookup 0x100 -> miss.
- flush_btb asserted in the same cycle as a taken update to 0x200 -> next lookup of 0x200 misses. Non-branch at 0x100 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104, entry invalidated.
- Drive 0xFFFF_FFFF lookups (force counter via preload) plus one more -> stat_lookups stays 0xFFFF_FFFF. Assert rst_n low asynchronously mid-cycle -> all outputs 0 immediately.
